rv_mem_harness: RTL
===================

// Module: rv_mem_harness
// PURPOSE
//  Parametrised instruction/data memory and run controller for rv32e_cpu benches and FPGA smoke tests.
//  Loads a program over a valid/ready port while holding the CPU in reset, then serves the imem/dmem ports.
//  Ends the run on a halt-address fetch or a cycle timeout.
//  Sits between the bench (or a UART loader) and rv32e_cpu; replaces ad-hoc per-bench memory models.
// PARAMETERS
//  DEPTH_WORDS   1024          words of unified memory; power of two
//  IMEM_REG      0             0: imem_data combinational from imem_addr; 1: registered, 1-cycle latency
//  HALT_ADDR     32'h0000_0024 fetch address that ends the run
//  MAX_CYCLES    10000         RUN-state cycle budget before timeout; must be >= 1
//  NOP_WORD      32'h0000_0013 imem_data returned for out-of-range fetches
// PORTS
//  clk              in   1   clock
//  reset            in   1   asynchronous, active-high reset
//  load_valid       in   1   load word offered
//  load_ready       out  1   load word accepted when valid&&ready
//  load_addr        in   32  byte address of load word; word-aligned
//  load_data        in   32  load word
//  load_last        in   1   marks final load beat
//  restart          in   1   in DONE/TIMEOUT: return to LOAD
//  cpu_hold         out  1   drive to rv32e_cpu reset
//  imem_addr        in   32  CPU fetch address
//  imem_read        in   1   CPU fetch strobe
//  imem_data        out  32  fetched word
//  dmem_addr        in   32  CPU data address
//  dmem_read        in   1   data read strobe
//  dmem_write       in   1   data write strobe
//  dmem_byte_enable in   4   byte lanes for write
//  dmem_data_out    in   32  CPU store data (CPU side naming)
//  dmem_data_in     out  32  load data to CPU
//  cycle_count      out  32  RUN cycles elapsed
//  done             out  1   halt reached
//  timeout          out  1   budget exhausted
//  oob_err          out  1   sticky: out-of-range access
//  align_err        out  1   sticky: misaligned data access (see CONFIGURATION)
// BEHAVIOUR
//  - FSM LOAD -> RUN -> {DONE | TIMEOUT} -> LOAD on restart.
//  - Reset (async): state=LOAD, cpu_hold=1, load_ready=1, cycle_count=0, done=timeout=oob_err=align_err=0.
//    imem_data = 0 when IMEM_REG=1. Memory contents retained across reset.
//  - LOAD: load_ready=1. Each valid&&ready writes mem[load_addr[AW+1:2]] at clk edge; AW=$clog2(DEPTH_WORDS).
//    Accepted beat with load_last -> RUN next cycle. Out-of-range load_addr: beat accepted, word dropped, oob_err set.
//  - RUN: cpu_hold=0, load_ready=0; cycle_count increments every cycle, saturating at 32'hFFFF_FFFF.
//  - imem_read && imem_addr==HALT_ADDR in RUN -> DONE next cycle. Else cycle_count==MAX_CYCLES-1 -> TIMEOUT.
//    Halt takes priority when both occur on the same cycle.
//  - DONE/TIMEOUT: cpu_hold=1; done or timeout held at 1; cycle_count frozen.
//    restart -> LOAD and clears done, timeout, cycle_count. Sticky errors clear only on reset.
//  - imem: word index imem_addr[AW+1:2]; imem_addr[1:0] ignored. Out-of-range returns NOP_WORD and sets oob_err (RUN only).
//  - dmem read: combinational; dmem_data_in = mem word when dmem_read, else 0; out-of-range reads return 0 and set oob_err.
//  - dmem write: at clk edge in RUN only; byte lane i written iff dmem_byte_enable[i].
//    Out-of-range writes are ignored and set oob_err.
//  - Same-cycle dmem write and fetch of the same word: fetch returns the old word (read-before-write).
//  - Reset asserted mid-RUN aborts immediately: cpu_hold=1 asynchronously.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - dmem access with byte_enable 4'b1111 and addr[1:0]!=0, or 4'b0011/4'b1100 and addr[0]=1, sets align_err.
//    - A misaligned write is suppressed; a misaligned read returns 0.
//  Not defined: align_err tied 0; addr[1:0] ignored; byte_enable applied as given.
// TESTING
//  1. Load 10-word branch program (addi/beq/jal), last beat at 0x24; run -> done=1, cycle_count<50, timeout=0, mem intact.
//  2. MAX_CYCLES=20, program loops at 0x00 (jal x0,0) -> timeout=1 when cycle_count=19; done=0; cpu_hold=1.
//  3. Store 0xDEADBEEF to 0x100 with be=4'b0101 over 0x11111111 -> reads back 0x11AD11EF.
//  4. Fetch at byte address DEPTH_WORDS*4 -> imem_data=0x00000013, oob_err=1; dmem write there leaves memory unchanged.
//  5. Assert reset at RUN cycle 5 -> cpu_hold=1 same cycle, state LOAD; reload nothing, load_last only -> program re-runs identically.
//  6. With MEM_ALIGN_CHECK_EN: sw to 0x102 -> align_err=1, word at 0x100 unchanged; without macro, word at 0x100 written.

Source files
------------

// File: rtl/rv_mem_harness.sv
// Unified instruction/data memory and run controller for rv32e_cpu benches.
// Optional misaligned-access checking is enabled by defining MEM_ALIGN_CHECK_EN.
module rv_mem_harness #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IMEM_REG    = 0,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_0024,
  parameter int unsigned MAX_CYCLES  = 10000,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        restart,
  output logic        cpu_hold,
  input  logic [31:0] imem_addr,
  input  logic        imem_read,
  output logic [31:0] imem_data,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_data_out,
  output logic [31:0] dmem_data_in,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        timeout,
  output logic        oob_err,
  output logic        align_err,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LAST_BUDGET_CYCLE = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0] mem [DEPTH_WORDS];

  // An address is in range when every bit above the word index is zero.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (AW + 2)) == 32'd0;
  endfunction

  logic [AW-1:0] load_idx;
  logic [AW-1:0] imem_idx;
  logic [AW-1:0] dmem_idx;
  logic          load_in;
  logic          imem_in;
  logic          dmem_in;
  logic          dmem_misaligned;
  logic          load_we;
  logic          dmem_we;
  logic          halt_hit;
  logic          budget_hit;
  logic          oob_set;
  logic [31:0]   imem_word;
  logic          unused_addr_bits;

  assign load_idx = load_addr[AW+1:2];
  assign imem_idx = imem_addr[AW+1:2];
  assign dmem_idx = dmem_addr[AW+1:2];
  assign load_in  = in_range(load_addr);
  assign imem_in  = in_range(imem_addr);
  assign dmem_in  = in_range(dmem_addr);

  // Byte offsets inside a word carry no meaning for fetch or load addressing.
  assign unused_addr_bits = ^{imem_addr[1:0], load_addr[1:0], dmem_addr[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign dmem_misaligned = (dmem_read || dmem_write) &&
    ((dmem_byte_enable == 4'b1111 && dmem_addr[1:0] != 2'b00) ||
     ((dmem_byte_enable == 4'b0011 || dmem_byte_enable == 4'b1100) && dmem_addr[0]));
`else
  assign dmem_misaligned = 1'b0;
`endif

  // Load handshake: load_ready is high throughout LOAD and low elsewhere; a beat
  // transfers on any clock edge where load_valid && load_ready, and a transferred
  // beat carrying load_last ends the load phase.
  assign load_we  = (state == ST_LOAD) && load_valid && load_in;
  assign dmem_we  = (state == ST_RUN) && dmem_write && dmem_in && !dmem_misaligned;

  assign halt_hit   = imem_read && (imem_addr == HALT_ADDR);
  assign budget_hit = (cycle_count == LAST_BUDGET_CYCLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cpu_hold   = 1'b1;
    load_ready = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && load_last) state_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        if (halt_hit) state_next = ST_DONE;
        else if (budget_hit) state_next = ST_TIMEOUT;
      end
      ST_DONE: begin
        done = 1'b1;
        if (restart) state_next = ST_LOAD;
      end
      ST_TIMEOUT: begin
        timeout = 1'b1;
        if (restart) state_next = ST_LOAD;
      end
      default: state_next = ST_LOAD;
    endcase
  end

  assign state_dbg = state;

  // The count advances only on RUN cycles that stay in RUN, so the value frozen in
  // DONE/TIMEOUT is the index of the cycle that ended the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (state == ST_RUN && state_next == ST_RUN) begin
      if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
    end else if ((state == ST_DONE || state == ST_TIMEOUT) && restart) begin
      cycle_count <= 32'd0;
    end
  end

  assign oob_set = ((state == ST_LOAD) && load_valid && !load_in) ||
                   ((state == ST_RUN) && imem_read && !imem_in) ||
                   ((state == ST_RUN) && (dmem_read || dmem_write) && !dmem_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_err <= 1'b0;
    end else if (oob_set) begin
      oob_err <= 1'b1;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err <= 1'b0;
    end else if (state == ST_RUN && dmem_misaligned) begin
      align_err <= 1'b1;
    end
  end
`else
  assign align_err = 1'b0;
`endif

  // Contents survive reset so a program can be re-run without reloading it.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_data;
    end else if (dmem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_byte_enable[i]) mem[dmem_idx][8*i +: 8] <= dmem_data_out[8*i +: 8];
      end
    end
  end

  assign imem_word = imem_in ? mem[imem_idx] : NOP_WORD;

  generate
    if (IMEM_REG != 0) begin : g_imem_reg
      logic [31:0] imem_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          imem_q <= 32'd0;
        end else begin
          imem_q <= imem_word;
        end
      end
      assign imem_data = imem_q;
    end else begin : g_imem_comb
      assign imem_data = imem_word;
    end
  endgenerate

  assign dmem_data_in = (dmem_read && dmem_in && !dmem_misaligned) ? mem[dmem_idx] : 32'd0;

endmodule
